// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the
// load/store unit, returning each response to its issuer and driving pipeline stalls.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_dm
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_IF = 3'd1,
        ISSUE_DM = 3'd2,
        WAIT     = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t                state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic                  mem_req_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   be_q;
    logic [DATA_W-1:0]     if_rdata_q;
    logic [DATA_W-1:0]     dm_rdata_q;
    logic                  if_valid_q;
    logic                  dm_valid_q;
    logic                  grant_dm_d;

    // Data wins a tie unless it also won the previous grant, so fetch cannot starve.
    assign grant_dm_d = dm_req & ~(if_req & last_grant_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            mem_req_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dm_req | if_req) begin
                        owner_q      <= grant_dm_d;
                        last_grant_q <= grant_dm_d;
                        mem_req_q    <= 1'b1;
                        if (grant_dm_d) begin
                            we_q    <= dm_we;
                            addr_q  <= dm_addr;
                            wdata_q <= dm_wdata;
                            be_q    <= dm_be;
                            state_q <= ISSUE_DM;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            be_q    <= '1;
                            state_q <= ISSUE_IF;
                        end
                    end
                end
                ISSUE_IF, ISSUE_DM: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // Responses outside WAIT (stray or after a reset) never reach here.
                    if (mem_rvalid) begin
                        if (owner_q) begin
                            dm_rdata_q <= mem_rdata;
                            dm_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_dm  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder model plus request and
// response scoreboards checked with immediate assertions.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [BW-1:0] dm_be = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_if;
    logic          stall_dm;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } req_t;

    typedef struct {
        bit            chk;
        logic [DW-1:0] data;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_if[$];
    rsp_t exp_dm[$];
    rsp_t mon_r;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: optional ready backpressure, response rsp_lat cycles after accept.
    int            ready_wait = 0;
    int            rsp_lat    = 1;
    bit            stray      = 1'b0;
    bit            acc        = 1'b0;
    logic [AW-1:0] acc_addr   = '0;
    int            rsp_cnt    = 0;
    logic [DW-1:0] rsp_val    = '0;

    always begin
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        if (acc) begin
            rsp_cnt = rsp_lat;
            rsp_val = mem_model(acc_addr);
            acc     = 1'b0;
        end
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_val;
            end
        end
        if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
            stray      = 1'b0;
        end
        mem_ready = 1'b0;
        if (mem_req) begin
            if (ready_wait > 0) ready_wait--;
            else begin
                mem_ready = 1'b1;
                acc       = 1'b1;
                acc_addr  = mem_addr;
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                check("mem_req_expected", 64'(exp_req.size() != 0), 64'd1);
                if (exp_req.size() != 0) begin
                    check("mem_we",    64'(mem_we),    64'(exp_req[0].we));
                    check("mem_addr",  64'(mem_addr),  64'(exp_req[0].addr));
                    check("mem_wdata", 64'(mem_wdata), 64'(exp_req[0].wdata));
                    check("mem_be",    64'(mem_be),    64'(exp_req[0].be));
                    if (mem_ready) void'(exp_req.pop_front());
                end
            end
            if (if_valid) begin
                check("if_valid_expected", 64'(exp_if.size() != 0), 64'd1);
                if (exp_if.size() != 0) begin
                    mon_r = exp_if.pop_front();
                    check("if_rdata", 64'(if_rdata), 64'(mon_r.data));
                end
            end
            if (dm_valid) begin
                check("dm_valid_expected", 64'(exp_dm.size() != 0), 64'd1);
                if (exp_dm.size() != 0) begin
                    mon_r = exp_dm.pop_front();
                    if (mon_r.chk) check("dm_rdata", 64'(dm_rdata), 64'(mon_r.data));
                end
            end
            if (if_valid && dm_valid) check("single_valid", 64'(if_valid & dm_valid), 64'd0);
        end
    end

    // Issue one request and hold it until its valid; drop it in the following IDLE cycle.
    task automatic access(input bit is_dm, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                          output int cyc, output int reqcyc);
        req_t q;
        rsp_t r;
        bit   got;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_be = be;
            q.we = we; q.addr = addr; q.wdata = wdata; q.be = be;
            r.chk = !we; r.data = mem_model(addr);
            exp_dm.push_back(r);
        end else begin
            if_req = 1'b1; if_addr = addr;
            q.we = 1'b0; q.addr = addr; q.wdata = '0; q.be = '1;
            r.chk = 1'b1; r.data = mem_model(addr);
            exp_if.push_back(r);
        end
        exp_req.push_back(q);
        #1;
        check(is_dm ? "stall_dm_c0" : "stall_if_c0", 64'(is_dm ? stall_dm : stall_if), 64'd1);
        cyc = 0; reqcyc = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_req) reqcyc++;
            got = is_dm ? dm_valid : if_valid;
            if (!got) check(is_dm ? "stall_dm_hold" : "stall_if_hold",
                            64'(is_dm ? stall_dm : stall_if), 64'd1);
        end
        check("valid_seen", 64'(got), 64'd1);
        check(is_dm ? "stall_dm_at_valid" : "stall_if_at_valid",
              64'(is_dm ? stall_dm : stall_if), 64'd0);
        @(posedge clk);
        #1;
        if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
    endtask

    int cyc, reqcyc, nv, cyc_count;
    int vcyc[4];
    bit seen_if;
    logic [DW-1:0] save_if, save_dm;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req",  64'(mem_req),  64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_dm_valid", 64'(dm_valid), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_dm_rdata", 64'(dm_rdata), 64'd0);
        check("rst_stall_if", 64'(stall_if), 64'd0);
        check("rst_stall_dm", 64'(stall_dm), 64'd0);
        rst = 1'b0;

        // Single load: valid on cycle 3, one mem_req cycle
        access(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, cyc, reqcyc);
        check("load_latency", 64'(cyc), 64'd3);
        check("load_req_cycles", 64'(reqcyc), 64'd1);
        check("load_rdata_held", 64'(dm_rdata), 64'hDEADBEEF);

        // Store with three cycles of ready backpressure
        ready_wait = 3;
        access(1'b1, 1'b1, 32'h180, 32'h1234, 4'h3, cyc, reqcyc);
        check("store_latency", 64'(cyc), 64'd6);
        check("store_req_cycles", 64'(reqcyc), 64'd4);

        // Back-to-back fetches: 4-cycle spacing
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b0, AW'(i * 4), '0, '0, cyc, reqcyc);
            check("fetch_latency", 64'(cyc), 64'd3);
            check("fetch_req_cycles", 64'(reqcyc), 64'd1);
        end

        // Simultaneous requests held from reset release: DM, IF, DM, IF
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_wdata = '0; dm_be = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_req.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
            exp_req.push_back('{1'b0, 32'h40, 32'h0, 4'hF});
            exp_dm.push_back('{1'b1, mem_model(32'h300)});
            exp_if.push_back('{1'b1, mem_model(32'h40)});
        end
        nv = 0; cyc_count = 0; seen_if = 1'b0;
        while (nv < 4 && cyc_count < 40) begin
            @(posedge clk);
            #1;
            cyc_count++;
            if (if_valid) seen_if = 1'b1;
            if (!seen_if) check("stall_if_until_valid", 64'(stall_if), 64'd1);
            if (if_valid || dm_valid) begin
                check(nv[0] ? "rr_if_turn" : "rr_dm_turn", 64'(if_valid), 64'(nv[0]));
                vcyc[nv] = cyc_count;
                nv++;
            end
        end
        check("rr_four_valids", 64'(nv), 64'd4);
        for (int i = 0; i < 4; i++) check("rr_valid_cycle", 64'(vcyc[i]), 64'(3 + 4 * i));
        @(posedge clk);
        #1;
        check("rr_idle_after_valid", 64'(mem_req), 64'd0);
        if_req = 1'b0; dm_req = 1'b0;

        // Reset while in WAIT; the late response must be ignored
        @(posedge clk);
        #1;
        rsp_lat = 3;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'hF;
        exp_req.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dm_req = 1'b0;
        check("rstw_mem_req", 64'(mem_req), 64'd0);
        check("rstw_dm_rdata", 64'(dm_rdata), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rstw_no_valid", 64'(dm_valid), 64'd0);
            check("rstw_mem_req_low", 64'(mem_req), 64'd0);
        end
        check("rstw_dm_rdata_kept", 64'(dm_rdata), 64'd0);
        rsp_lat = 1;
        access(1'b1, 1'b0, 32'h204, 32'h0, 4'hF, cyc, reqcyc);
        check("post_rst_latency", 64'(cyc), 64'd3);

        // Stray response while IDLE
        save_if = if_rdata;
        save_dm = dm_rdata;
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stray_if_valid", 64'(if_valid), 64'd0);
            check("stray_dm_valid", 64'(dm_valid), 64'd0);
        end
        check("stray_if_rdata", 64'(if_rdata), 64'(save_if));
        check("stray_dm_rdata", 64'(dm_rdata), 64'(save_dm));

        repeat (2) @(posedge clk);
        check("left_req", 64'(exp_req.size()), 64'd0);
        check("left_if",  64'(exp_if.size()),  64'd0);
        check("left_dm",  64'(exp_dm.size()),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch stage and the memory stage's load/store unit. It handshakes each request onto the port and returns the response to the requester that issued it. It also generates the fetch and memory-stage stall signals that freeze the pipeline while an access is outstanding. Data accesses normally win, and a round-robin override guarantees fetch cannot starve.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid when if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held with all dm_* stable until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data, valid when dm_valid
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_req  out  1  port request
- mem_we, mem_addr, mem_wdata, mem_be  out  as above  port attributes
- mem_ready  in  1  port accepts request this cycle
- mem_rvalid  in  1  response/ack for the accepted request (stores also ack)
- mem_rdata  in  DATA_W  response data
- stall_if  out  1  freeze fetch/decode
- stall_dm  out  1  freeze memory stage and older stages

## Operation
- Registered FSM with five states: IDLE, ISSUE_IF, ISSUE_DM, WAIT, RESP. A registered owner bit (0 = IF, 1 = DM) and a last_grant bit accompany the state.
- IDLE, grant selection:
  - Only dm_req: grant DM.
  - Only if_req: grant IF.
  - Both: grant DM unless last_grant = DM, then grant IF.
  - Neither: stay in IDLE.
  - Grant sets owner and last_grant, latches the selected request's attributes into port registers, and moves to ISSUE_IF or ISSUE_DM.
- ISSUE_x:
  - mem_req = 1; mem_* driven from the latched registers.
  - Stay until mem_ready = 1, then go to WAIT.
  - Fetch port reads: mem_we = 0, mem_be = all ones, mem_wdata = 0.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid: latch mem_rdata into the owner's rdata register and go to RESP.
  - mem_rvalid in any state other than WAIT is ignored.
- RESP:
  - Pulse the owner's valid for exactly this cycle; no new grant is made.
  - Go to IDLE next cycle. This lets the requester drop or change its request before re-arbitration.
- if_rdata and dm_rdata hold their last value until overwritten.
- dm_rdata is also written on store acks, with don't-care data.
- stall_if = if_req & ~if_valid. stall_dm = dm_req & ~dm_valid. Both are combinational.
- Requests are not cancellable. A deasserted req while its access is in flight does not abort it; the valid pulse still occurs.

## Timing
- Reset values: state IDLE, owner 0, last_grant 0, all valid outputs 0, mem_req 0, rdata registers 0.
- Reset mid-access drops the transaction. Its late mem_rvalid is ignored because the FSM is no longer in WAIT.
- Best-case latency, request seen in IDLE at cycle 0:
  - Cycle 1: mem_req with mem_ready = 1.
  - Cycle 2: mem_rvalid in WAIT.
  - Cycle 3: valid pulse.
  - Cycle 4: IDLE, earliest next grant.
- Each mem_ready stall cycle and each WAIT cycle adds one cycle.
- At most one transaction is outstanding. mem_req is never asserted in WAIT, RESP or IDLE.
- mem_* attributes are constant from the ISSUE entry cycle until acceptance.

## Test plan
- Single load:
  - Stimulus: dm_req = 1, dm_we = 0, dm_addr = 0x100; mem_ready = 1; mem_rvalid one cycle after acceptance with rdata 0xDEADBEEF.
  - Response: mem_req high for one cycle with addr 0x100, dm_valid pulse at cycle 3 with dm_rdata = 0xDEADBEEF, stall_dm high in cycles 0–2.
- Store with ready backpressure:
  - Stimulus: dm_we = 1, be = 0x3, wdata = 0x1234; mem_ready low for 3 cycles.
  - Response: mem_req/addr/wdata/be held for 4 cycles, then ack, then one dm_valid pulse; no duplicate mem_req.
- Simultaneous requests:
  - Stimulus: if_req and dm_req held continuously after reset.
  - Response: grant order DM, IF, DM, IF; each valid pulse is followed by exactly one IDLE cycle; stall_if stays high until its valid.
- Fetch only:
  - Stimulus: if_req with addr 0x0, 0x4, 0x8 issued back-to-back.
  - Response: three if_valid pulses 4 cycles apart, if_rdata matches memory each time, mem_we = 0, mem_be = 0xF.
- Reset mid-WAIT:
  - Stimulus: rst asserted while in WAIT, then mem_rvalid arrives after reset.
  - Response: no valid pulse, mem_req = 0, FSM in IDLE; a following request completes normally.
- Stray response:
  - Stimulus: mem_rvalid asserted while in IDLE.
  - Response: no valid pulse and no rdata change.
